// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side transmit path: FSM encoding,
// frame length and the odd-parity rule.
package ps2_pkg;

   typedef logic [2:0] ps2_state_t;

   localparam ps2_state_t ST_IDLE      = 3'd0;
   localparam ps2_state_t ST_INHIBIT   = 3'd1;
   localparam ps2_state_t ST_RTS       = 3'd2;
   localparam ps2_state_t ST_SEND      = 3'd3;
   localparam ps2_state_t ST_WAIT_IDLE = 3'd4;

   // Start bit is driven during RTS, so the device clocks 11 edges:
   // 8 data, parity, stop and the ACK slot.
   localparam int unsigned PS2_FRAME_BITS = 11;

   localparam int unsigned CNT_W = 20;

   // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sincronizator.sv
// Two-flop synchroniser for the raw PS/2 clock and data lines, with a
// one-cycle pulse on each falling edge of the synchronised clock.
module ps2_sincronizator (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_sync_o,
   output logic data_sync_o,
   output logic clk_fe_o
);

   logic [1:0] clk_ff_q;
   logic [1:0] data_ff_q;
   logic       clk_prev_q;

   // Reset to the idle-high bus level so no spurious edge follows reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_ff_q   <= 2'b11;
         data_ff_q  <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
         data_ff_q  <= {data_ff_q[0], ps2_data_i};
         clk_prev_q <= clk_ff_q[1];
      end
   end

   assign clk_sync_o  = clk_ff_q[1];
   assign data_sync_o = data_ff_q[1];
   assign clk_fe_o    = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_transmitator.sv
// Host-to-device PS/2 byte transmitter: request-to-send, clocks out a frame
// on device-generated clock edges, checks the ACK and bounds the transfer time.
module ps2_transmitator
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYC = 5000,
   parameter int unsigned TIMEOUT_CYC = 750000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_data_oe_o
);

   localparam logic [CNT_W-1:0] InhibitLoad = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0] TimeoutLoad = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic             InhibitOne  = (INHIBIT_CYC == 1);

   logic clk_sync;
   logic data_sync;
   logic clk_fe;

   ps2_sincronizator u_sync (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_data_i  (ps2_data_i),
      .clk_sync_o  (clk_sync),
      .data_sync_o (data_sync),
      .clk_fe_o    (clk_fe)
   );

   ps2_state_t       state_q, state_d;
   logic [7:0]       data_q, data_d;
   logic             par_q, par_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             tmo_hit;

   // The shared down-counter doubles as the timeout budget once the clock is released.
   assign tmo_hit = ((state_q == ST_SEND) || (state_q == ST_WAIT_IDLE)) && (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      par_d     = par_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;

      if (tmo_hit) begin
         state_d   = ST_IDLE;
         busy_d    = 1'b0;
         err_d     = 1'b1;
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               if (start_i) begin
                  data_d    = data_i;
                  par_d     = odd_parity(data_i);
                  bit_cnt_d = 4'd0;
                  cnt_d     = InhibitLoad;
                  busy_d    = 1'b1;
                  clk_oe_d  = 1'b1;
                  data_oe_d = InhibitOne;
                  state_d   = ST_INHIBIT;
               end
            end

            ST_INHIBIT: begin
               if (cnt_q == '0) begin
                  clk_oe_d = 1'b0;
                  cnt_d    = TimeoutLoad;
                  state_d  = ST_RTS;
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == CNT_W'(1)) begin
                     data_oe_d = 1'b1;
                  end
               end
            end

            ST_RTS: begin
               cnt_d   = cnt_q - 1'b1;
               state_d = ST_SEND;
            end

            ST_SEND: begin
               cnt_d = cnt_q - 1'b1;
               if (clk_fe) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_d == 4'(PS2_FRAME_BITS)) begin
                     data_oe_d = 1'b0;
                     if (data_sync) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                     end else begin
                        state_d = ST_WAIT_IDLE;
                     end
                  end else if (bit_cnt_d == 4'(PS2_FRAME_BITS - 1)) begin
                     data_oe_d = 1'b0;
                  end else if (bit_cnt_d == 4'(PS2_FRAME_BITS - 2)) begin
                     data_oe_d = ~par_q;
                  end else begin
                     data_oe_d = ~data_q[bit_cnt_q[2:0]];
                  end
               end
            end

            ST_WAIT_IDLE: begin
               cnt_d = cnt_q - 1'b1;
               if (clk_sync && data_sync) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end

            default: begin
               state_d   = ST_IDLE;
               busy_d    = 1'b0;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         data_q    <= 8'h00;
         par_q     <= 1'b0;
         bit_cnt_q <= 4'd0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         par_q     <= par_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign ps2_clk_oe_o  = clk_oe_q;
   assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_transmitator.sv
// Directed bench for ps2_transmitator with an open-drain bus and a simple
// PS/2 device model that clocks frames at a 40-cycle period.
module tb_ps2_transmitator;

   localparam int unsigned INH = 20;
   localparam int unsigned TMO = 2000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       busy, done, err, clk_oe, data_oe;
   logic       dev_clk_pull = 1'b0;
   logic       dev_data_pull = 1'b0;
   logic       clk_line, data_line;

   assign clk_line  = ~(clk_oe | dev_clk_pull);
   assign data_line = ~(data_oe | dev_data_pull);

   always #5 clk = ~clk;

   ps2_transmitator #(
      .INHIBIT_CYC (INH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .data_i        (data_in),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err),
      .ps2_clk_i     (clk_line),
      .ps2_data_i    (data_line),
      .ps2_clk_oe_o  (clk_oe),
      .ps2_data_oe_o (data_oe)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Cumulative bus monitor, sampled on the falling clock edge.
   int   cyc = 0, n_done = 0, n_err = 0, n_both = 0, n_long = 0;
   int   oe_len = 0, doe_inh = 0, busy_rises = 0, busy_falls = 0;
   int   rel_time = 0, err_time = 0;
   logic last_doe = 1'b0, busy_p = 1'b0, clk_oe_p = 1'b0, done_p = 1'b0, err_p = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      if (done === 1'b1 && err === 1'b1) n_both++;
      if ((done === 1'b1 && done_p) || (err === 1'b1 && err_p)) n_long++;
      if (err === 1'b1 && !err_p) err_time = cyc;
      if (clk_oe === 1'b1) begin
         oe_len++;
         last_doe = data_oe;
         if (data_oe === 1'b1) doe_inh++;
      end
      if (clk_oe_p && clk_oe === 1'b0) rel_time = cyc;
      if (!busy_p && busy === 1'b1) busy_rises++;
      if (busy_p && busy === 1'b0) busy_falls++;
      busy_p   = (busy === 1'b1);
      clk_oe_p = (clk_oe === 1'b1);
      done_p   = (done === 1'b1);
      err_p    = (err === 1'b1);
   end

   logic [9:0] dev_bits;
   logic       dev_ok;

   // Device side: waits for request-to-send, then clocks 11 edges, sampling
   // the host bit while its clock is low and optionally ACKing.
   task automatic dev_frame(input logic ack, input logic clocks);
      int k;
      dev_bits = '0;
      dev_ok   = 1'b0;
      k = 0;
      while (clk_oe !== 1'b1 && k < 200) begin @(posedge clk); k++; end
      while (clk_oe === 1'b1 && k < 400) begin @(posedge clk); k++; end
      if (k >= 400) return;
      dev_ok = 1'b1;
      if (!clocks) return;
      repeat (10) @(posedge clk);
      for (int i = 0; i < 11; i++) begin
         dev_clk_pull = 1'b1;
         repeat (20) @(posedge clk);
         if (i < 10) dev_bits[i] = data_line;
         dev_clk_pull = 1'b0;
         if (i == 9 && ack) dev_data_pull = 1'b1;
         repeat (20) @(posedge clk);
      end
      dev_data_pull = 1'b0;
   endtask

   task automatic send_start(input logic [7:0] d);
      @(posedge clk);
      #1 start = 1'b1;
      data_in = d;
      @(negedge clk);
      check("busy_before_accept", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy === 1'b1 && k < 5000) begin @(posedge clk); k++; end
      #1;
      check({name, "_idle_reached"}, {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       ack;
      int         exp_done;
      int         exp_err;
   } vec_t;

   vec_t vecs[4];
   int   b_done, b_err, b_both, b_long, b_oe, b_doe, b_rise, b_fall;

   task automatic snap();
      b_done = n_done; b_err = n_err; b_both = n_both; b_long = n_long;
      b_oe = oe_len; b_doe = doe_inh; b_rise = busy_rises; b_fall = busy_falls;
   endtask

   initial begin
      #100000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
      vecs[1] = '{8'h07, 1'b0, 1'b1, 1, 0};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1, 0};
      vecs[3] = '{8'hA5, 1'b1, 1'b0, 0, 1};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done_err", {30'd0, done, err}, 32'd0);
      check("rst_oe", {30'd0, clk_oe, data_oe}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // Device traffic while idle must not start anything.
      snap();
      for (int i = 0; i < 3; i++) begin
         dev_clk_pull = 1'b1;
         repeat (20) @(posedge clk);
         dev_clk_pull = 1'b0;
         repeat (20) @(posedge clk);
      end
      check("idle_fe_busy", busy_rises - b_rise, 0);
      check("idle_fe_pulses", (n_done - b_done) + (n_err - b_err), 0);

      // Reset asserted mid-SEND, while data_oe is pulled for a 0 bit.
      send_start(8'hED);
      k = 0;
      while (clk_oe === 1'b1 && k < 100) begin @(posedge clk); k++; end
      repeat (10) @(posedge clk);
      dev_clk_pull = 1'b1;
      repeat (20) @(posedge clk);
      dev_clk_pull = 1'b0;
      repeat (20) @(posedge clk);
      dev_clk_pull = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("pre_rst_data_oe", {31'd0, data_oe}, 32'd1);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_oe", {30'd0, clk_oe, data_oe}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      dev_clk_pull = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      snap();
      rst_n = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      check("post_rst_pulses", (n_done - b_done) + (n_err - b_err), 0);
      check("post_rst_busy_oe", {29'd0, busy, clk_oe, data_oe}, 32'd0);

      // Table-driven frames.
      for (int v = 0; v < 4; v++) begin
         snap();
         send_start(vecs[v].data);
         dev_frame(vecs[v].ack, 1'b1);
         wait_idle($sformatf("v%0d", v));
         repeat (5) @(posedge clk);
         #1;
         check($sformatf("v%0d_dev_ok", v), {31'd0, dev_ok}, 32'd1);
         check($sformatf("v%0d_bits", v), {22'd0, dev_bits}, {22'd0, 1'b1, vecs[v].par, vecs[v].data});
         check($sformatf("v%0d_inhibit_len", v), oe_len - b_oe, INH);
         check($sformatf("v%0d_inhibit_data_oe_cycles", v), doe_inh - b_doe, 1);
         check($sformatf("v%0d_inhibit_last_data_oe", v), {31'd0, last_doe}, 32'd1);
         check($sformatf("v%0d_done", v), n_done - b_done, vecs[v].exp_done);
         check($sformatf("v%0d_err", v), n_err - b_err, vecs[v].exp_err);
         check($sformatf("v%0d_both", v), n_both - b_both, 0);
         check($sformatf("v%0d_long_pulse", v), n_long - b_long, 0);
         check($sformatf("v%0d_busy_falls", v), busy_falls - b_fall, 1);
         check($sformatf("v%0d_released", v), {30'd0, clk_oe, data_oe}, 32'd0);
      end

      // Device never clocks: timeout counted from clock release.
      snap();
      send_start(8'h12);
      dev_frame(1'b0, 1'b0);
      wait_idle("tmo");
      repeat (3) @(posedge clk);
      #1;
      check("tmo_dev_ok", {31'd0, dev_ok}, 32'd1);
      check("tmo_latency", err_time - rel_time, TMO);
      check("tmo_err", n_err - b_err, 1);
      check("tmo_done", n_done - b_done, 0);
      check("tmo_long_pulse", n_long - b_long, 0);
      check("tmo_released", {30'd0, clk_oe, data_oe}, 32'd0);

      // Second start during SEND is ignored.
      snap();
      send_start(8'hED);
      fork
         dev_frame(1'b1, 1'b1);
         begin
            repeat (200) @(posedge clk);
            #1 start = 1'b1;
            data_in = 8'h55;
            @(posedge clk);
            #1 start = 1'b0;
         end
      join
      wait_idle("dup");
      repeat (50) @(posedge clk);
      #1;
      check("dup_bits", {22'd0, dev_bits}, {22'd0, 1'b1, 1'b1, 8'hED});
      check("dup_done", n_done - b_done, 1);
      check("dup_err", n_err - b_err, 0);
      check("dup_busy_rises", busy_rises - b_rise, 1);
      check("dup_busy_falls", busy_falls - b_fall, 1);
      check("dup_busy_after", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
